// File: rtl/cbc16_nibble_sequencer_if.sv
// Handshake bundle for the nibble sequencer: the plaintext word goes in and the ciphertext word comes out.
// Both channels transfer on a rising edge where valid && ready; a producer holds valid and its payload until then.
interface cbc16_nibble_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_key;
  logic [3:0]  in_iv;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_iv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_iv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cbc16_nibble_sequencer.sv
// Feeds a 16-bit word through an external 4-bit cipher core one nibble per clock,
// optionally CBC-chained, and returns the assembled ciphertext over a valid/ready port.
module cbc16_nibble_sequencer #(
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  cbc16_nibble_sequencer_if.slave         bus,
  output logic [3:0]                      cph_p,
  output logic [3:0]                      cph_k,
  input  logic [3:0]                      cph_c,
  output logic                            busy,
  output logic [1:0]                      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [3:0]  key_r;
  logic [3:0]  chain_r;
  logic [15:0] pt_r;
  logic [15:0] ct_r;
  logic [3:0]  pt_nib;

  assign pt_nib = pt_r[cnt*4 +: 4];

  // Handshake flags depend on state only, so no combinational path from valid/ready.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = ct_r;
  assign busy          = (state == S_RUN) || (state == S_DONE);
  assign dbg_state     = state;

  assign cph_p = (state == S_RUN) ? (pt_nib ^ chain_r) : 4'h0;
  assign cph_k = key_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      key_r   <= 4'h0;
      chain_r <= 4'h0;
      pt_r    <= 16'h0000;
      ct_r    <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            pt_r    <= bus.in_data;
            key_r   <= bus.in_key;
            chain_r <= CHAIN_EN ? bus.in_iv : 4'h0;
            cnt     <= 2'd0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          ct_r[cnt*4 +: 4] <= cph_c;
          chain_r          <= CHAIN_EN ? cph_c : 4'h0;
          cnt              <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Exiting takes the whole edge; a waiting word is accepted on the next one.
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
